acc_core: RTL and testbench

Parametrised accumulator processor core: the next-generation successor to the fixed 8-bit, 9-bit-opcode accumulator top level. It integrates the PC/sequencer, register file, ALU, carry flag and run counters into one block. Width and register count are configurable. Data memory is reached through a req/ack handshake with wait states, instead of a fixed single-cycle memory. Instruction memory stays external and is read combinationally.

---
 rtl/acc_core.sv | 286 ++++++++++++++++++++++++++++
 tb/tb_acc_core.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_core.sv
// acc_core: parametrised accumulator core with PC/sequencer, register
// file, ALU, carry flag, saturating run counters and a req/ack data port.
//
// Ports:
//   CLK, RST_n      clock, asynchronous active-low reset
//   start           synchronous restart into RUN (priority over all)
//   instr_addr      current PC; instr_in is the word at that address
//   instr_in        {type, op[3:0], field[PC_W-1:0]}, read same cycle
//   mem_req/we      registered data request, 1 = store
//   mem_addr/wdata  request address and store data, held until mem_ack
//   mem_rdata/ack   load data and completion strobe
//   Halt            core halted (registered)
//   acc_out         accumulator
//   cycle_ct        saturating count of RUN + MEM_WAIT cycles
//   instr_ct        saturating count of retired instructions
//   stall_ct        MEM_WAIT cycles; present only with ACC_CORE_STALL_CNT_EN
//
// Optional feature macro: ACC_CORE_STALL_CNT_EN.

module acc_core #(
    parameter int DATA_W = 8,
    parameter int REG_N  = 16,
    parameter int PC_W   = 8,
    parameter int CNT_W  = 32
) (
    input  logic              CLK,
    input  logic              RST_n,
    input  logic              start,
    output logic [PC_W-1:0]   instr_addr,
    input  logic [PC_W+4:0]   instr_in,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              Halt,
    output logic [DATA_W-1:0] acc_out,
    output logic [CNT_W-1:0]  cycle_ct,
    output logic [CNT_W-1:0]  instr_ct
`ifdef ACC_CORE_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_ct
`endif
);

    localparam int INSTR_W = 5 + PC_W;
    localparam int RS_W    = (REG_N > 1) ? $clog2(REG_N) : 1;

    localparam logic [PC_W-1:0]  PC_ONE  = 1;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    // type=0 opcodes
    localparam logic [3:0] OP_LDA  = 4'd0;
    localparam logic [3:0] OP_STA  = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_OR   = 4'd5;
    localparam logic [3:0] OP_XOR  = 4'd6;
    localparam logic [3:0] OP_SHL  = 4'd7;
    localparam logic [3:0] OP_SHR  = 4'd8;
    localparam logic [3:0] OP_LD   = 4'd9;
    localparam logic [3:0] OP_ST   = 4'd10;
    localparam logic [3:0] OP_CLC  = 4'd11;
    localparam logic [3:0] OP_HALT = 4'd15;

    // type=1 opcodes
    localparam logic [3:0] OP_BZ   = 4'd0;
    localparam logic [3:0] OP_JMP  = 4'd1;
    localparam logic [3:0] OP_LDI  = 4'd2;

    typedef enum logic [1:0] {
        S_HALTED   = 2'd0,
        S_RUN      = 2'd1,
        S_MEM_WAIT = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic              c_q, c_d;
    logic [DATA_W-1:0] regs_q [REG_N];
    logic              reg_we;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [CNT_W-1:0]  cyc_q, cyc_d;
    logic [CNT_W-1:0]  ins_q, ins_d;
    logic              cyc_inc;
    logic              ins_inc;
`ifdef ACC_CORE_STALL_CNT_EN
    logic [CNT_W-1:0]  stall_q, stall_d;
    logic              stall_inc;
`endif

    // Instruction fields
    logic                   ityp;
    logic [3:0]             op;
    logic [PC_W-1:0]        field;
    logic [RS_W-1:0]        rs;
    logic [DATA_W-1:0]      rval;
    logic [PC_W-1:0]        pc_inc;
    logic [DATA_W:0]        add_res;
    logic [DATA_W:0]        sub_res;
    logic [DATA_W+PC_W-1:0] ldi_wide;
    logic [DATA_W-1:0]      ldi_val;

    assign ityp  = instr_in[INSTR_W-1];
    assign op    = instr_in[PC_W+3:PC_W];
    assign field = instr_in[PC_W-1:0];
    assign rs    = field[RS_W-1:0];
    assign rval  = regs_q[rs];

    assign pc_inc = pc_q + PC_ONE;

    // Carry-in is part of both ADD and SUB; SUB's top bit is the borrow.
    assign add_res = {1'b0, acc_q} + {1'b0, rval}
                   + {{DATA_W{1'b0}}, c_q};
    assign sub_res = {1'b0, acc_q} - {1'b0, rval}
                   - {{DATA_W{1'b0}}, c_q};

    // Zero-extend or truncate the immediate to DATA_W
    assign ldi_wide = {{DATA_W{1'b0}}, field};
    assign ldi_val  = ldi_wide[DATA_W-1:0];

    function automatic logic [CNT_W-1:0] sat_inc(
        input logic [CNT_W-1:0] v
    );
        return (&v) ? v : v + CNT_ONE;
    endfunction

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        acc_d   = acc_q;
        c_d     = c_q;
        reg_we  = 1'b0;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cyc_d   = cyc_q;
        ins_d   = ins_q;
        cyc_inc = 1'b0;
        ins_inc = 1'b0;
`ifdef ACC_CORE_STALL_CNT_EN
        stall_d   = stall_q;
        stall_inc = 1'b0;
`endif

        case (state_q)
            S_RUN: begin
                cyc_inc = 1'b1;
                ins_inc = 1'b1;
                pc_d    = pc_inc;
                if (!ityp) begin
                    case (op)
                        OP_LDA: acc_d = rval;
                        OP_STA: reg_we = 1'b1;
                        OP_ADD: {c_d, acc_d} = add_res;
                        OP_SUB: {c_d, acc_d} = sub_res;
                        OP_AND: acc_d = acc_q & rval;
                        OP_OR:  acc_d = acc_q | rval;
                        OP_XOR: acc_d = acc_q ^ rval;
                        OP_SHL: {c_d, acc_d} = {acc_q, 1'b0};
                        OP_SHR: {acc_d, c_d} = {1'b0, acc_q};
                        OP_LD, OP_ST: begin
                            // Retires and advances on mem_ack
                            ins_inc = 1'b0;
                            pc_d    = pc_q;
                            req_d   = 1'b1;
                            we_d    = (op == OP_ST);
                            addr_d  = rval;
                            wdata_d = acc_q;
                            state_d = S_MEM_WAIT;
                        end
                        OP_CLC: c_d = 1'b0;
                        OP_HALT: begin
                            ins_inc = 1'b0;
                            pc_d    = pc_q;
                            state_d = S_HALTED;
                        end
                        default: ;
                    endcase
                end else begin
                    case (op)
                        OP_BZ:  if (acc_q == '0) pc_d = field;
                        OP_JMP: pc_d = field;
                        OP_LDI: acc_d = ldi_val;
                        default: ;
                    endcase
                end
            end
            S_MEM_WAIT: begin
                cyc_inc = 1'b1;
`ifdef ACC_CORE_STALL_CNT_EN
                stall_inc = 1'b1;
`endif
                if (mem_ack) begin
                    ins_inc = 1'b1;
                    pc_d    = pc_inc;
                    req_d   = 1'b0;
                    state_d = S_RUN;
                    if (!we_q) acc_d = mem_rdata;
                end
            end
            S_HALTED: ;
            default: state_d = S_HALTED;
        endcase

        if (cyc_inc) cyc_d = sat_inc(cyc_q);
        if (ins_inc) ins_d = sat_inc(ins_q);
`ifdef ACC_CORE_STALL_CNT_EN
        if (stall_inc) stall_d = sat_inc(stall_q);
`endif

        // Restart overrides the whole cycle; registers are kept.
        if (start) begin
            state_d = S_RUN;
            pc_d    = '0;
            acc_d   = '0;
            c_d     = 1'b0;
            reg_we  = 1'b0;
            req_d   = 1'b0;
            cyc_d   = '0;
            ins_d   = '0;
`ifdef ACC_CORE_STALL_CNT_EN
            stall_d = '0;
`endif
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q <= S_HALTED;
            pc_q    <= '0;
            acc_q   <= '0;
            c_q     <= 1'b0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cyc_q   <= '0;
            ins_q   <= '0;
`ifdef ACC_CORE_STALL_CNT_EN
            stall_q <= '0;
`endif
            for (int i = 0; i < REG_N; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            acc_q   <= acc_d;
            c_q     <= c_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cyc_q   <= cyc_d;
            ins_q   <= ins_d;
`ifdef ACC_CORE_STALL_CNT_EN
            stall_q <= stall_d;
`endif
            if (reg_we) begin
                regs_q[rs] <= acc_q;
            end
        end
    end

    assign instr_addr = pc_q;
    assign mem_req    = req_q;
    assign mem_we     = we_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign Halt       = (state_q == S_HALTED);
    assign acc_out    = acc_q;
    assign cycle_ct   = cyc_q;
    assign instr_ct   = ins_q;
`ifdef ACC_CORE_STALL_CNT_EN
    assign stall_ct   = stall_q;
`endif

endmodule

// File: tb/tb_acc_core.sv
// tb_acc_core: directed bench for acc_core with hand-computed results.
// A second instance with CNT_W=4 exercises counter saturation.

module tb_acc_core;

    logic        CLK;
    logic        RST_n;
    logic        start;
    logic [7:0]  instr_addr;
    logic [12:0] instr_in;
    logic        mem_req;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_ack;
    logic        Halt;
    logic [7:0]  acc_out;
    logic [31:0] cycle_ct;
    logic [31:0] instr_ct;
`ifdef ACC_CORE_STALL_CNT_EN
    logic [31:0] stall_ct;
    logic [3:0]  stall_ct2;
`endif

    logic        start2;
    logic [7:0]  instr_addr2;
    logic        mem_req2;
    logic        mem_we2;
    logic [7:0]  mem_addr2;
    logic [7:0]  mem_wdata2;
    logic        Halt2;
    logic [7:0]  acc_out2;
    logic [3:0]  cycle_ct2;
    logic [3:0]  instr_ct2;

    logic [12:0] imem [0:255];

    int errors = 0;
    int checks = 0;

    assign instr_in = imem[instr_addr];

    acc_core dut (
        .CLK(CLK), .RST_n(RST_n), .start(start),
        .instr_addr(instr_addr), .instr_in(instr_in),
        .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .Halt(Halt), .acc_out(acc_out),
        .cycle_ct(cycle_ct), .instr_ct(instr_ct)
`ifdef ACC_CORE_STALL_CNT_EN
        , .stall_ct(stall_ct)
`endif
    );

    // Runs a JMP 0 loop forever: one retired instruction per cycle
    acc_core #(.CNT_W(4)) dut2 (
        .CLK(CLK), .RST_n(RST_n), .start(start2),
        .instr_addr(instr_addr2), .instr_in(13'h1100),
        .mem_req(mem_req2), .mem_we(mem_we2),
        .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
        .mem_rdata(8'h00), .mem_ack(1'b0),
        .Halt(Halt2), .acc_out(acc_out2),
        .cycle_ct(cycle_ct2), .instr_ct(instr_ct2)
`ifdef ACC_CORE_STALL_CNT_EN
        , .stall_ct(stall_ct2)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [12:0] enc(
        input logic t, input logic [3:0] op, input logic [7:0] f
    );
        return {t, op, f};
    endfunction

    task automatic clear_imem();
        for (int i = 0; i < 256; i++) imem[i] = enc(1'b0, 4'd12, 8'h00);
    endtask

    task automatic pulse_start();
        @(negedge CLK); start = 1'b1;
        @(negedge CLK); start = 1'b0;
    endtask

    task automatic wait_halt(input int maxc);
        int n;
        n = 0;
        while (!Halt && n < maxc) begin
            @(negedge CLK);
            n++;
        end
        checks++;
        if (!Halt) begin
            errors++;
            $display("FAIL halt_timeout: Halt=%0b required 1", Halt);
        end
    endtask

    task automatic test_reset();
        RST_n = 1'b0; start = 1'b0; start2 = 1'b0;
        mem_ack = 1'b0; mem_rdata = 8'h00;
        clear_imem();
        #22;
        checks++;
        if (Halt !== 1'b1) begin
            errors++; $display("FAIL rst_halt: got %b exp 1", Halt);
        end
        checks++;
        if (acc_out !== 8'h00 || instr_addr !== 8'h00) begin
            errors++;
            $display("FAIL rst_acc_pc: got %h/%h exp 00/00",
                     acc_out, instr_addr);
        end
        checks++;
        if (mem_req !== 1'b0 || mem_addr !== 8'h00) begin
            errors++;
            $display("FAIL rst_mem: got %b/%h exp 0/00", mem_req, mem_addr);
        end
        checks++;
        if (cycle_ct !== 0 || instr_ct !== 0) begin
            errors++;
            $display("FAIL rst_cnt: got %0d/%0d exp 0/0", cycle_ct, instr_ct);
        end
        @(negedge CLK); RST_n = 1'b1;
        @(negedge CLK);
        checks++;
        if (Halt !== 1'b1 || cycle_ct !== 0) begin
            errors++;
            $display("FAIL idle_halted: got %b/%0d exp 1/0", Halt, cycle_ct);
        end
    endtask

    task automatic test_add_prog();
        clear_imem();
        imem[0] = enc(1, 4'd2, 8'd5);
        imem[1] = enc(0, 4'd1, 8'd1);
        imem[2] = enc(1, 4'd2, 8'd3);
        imem[3] = enc(0, 4'd2, 8'd1);
        imem[4] = enc(0, 4'd15, 8'd0);
        pulse_start();
        checks++;
        if (Halt !== 1'b0 || instr_addr !== 8'h00) begin
            errors++;
            $display("FAIL start_run: got %b/%h exp 0/00", Halt, instr_addr);
        end
        wait_halt(20);
        checks++;
        if (acc_out !== 8'h08) begin
            errors++; $display("FAIL add_acc: got %h exp 08", acc_out);
        end
        checks++;
        if (instr_ct !== 4 || cycle_ct !== 5) begin
            errors++;
            $display("FAIL add_cnt: got %0d/%0d exp 4/5", instr_ct, cycle_ct);
        end
        checks++;
        if (instr_addr !== 8'h04) begin
            errors++; $display("FAIL halt_pc: got %h exp 04", instr_addr);
        end
    endtask

    task automatic test_carry_bz();
        clear_imem();
        imem[0]     = enc(1, 4'd2, 8'hFF);
        imem[1]     = enc(0, 4'd1, 8'd2);
        imem[2]     = enc(1, 4'd2, 8'd1);
        imem[3]     = enc(0, 4'd2, 8'd2);
        imem[4]     = enc(1, 4'd0, 8'h20);
        imem[8'h20] = enc(0, 4'd2, 8'd0);
        imem[8'h21] = enc(0, 4'd2, 8'd1);
        imem[8'h22] = enc(0, 4'd15, 8'd0);
        pulse_start();
        repeat (4) @(negedge CLK);
        checks++;
        if (acc_out !== 8'h00) begin
            errors++; $display("FAIL carry_acc: got %h exp 00", acc_out);
        end
        @(negedge CLK);
        checks++;
        if (instr_addr !== 8'h20) begin
            errors++; $display("FAIL bz_taken: got %h exp 20", instr_addr);
        end
        @(negedge CLK);
        // ADD r0 with C=1 gives 1
        checks++;
        if (acc_out !== 8'h01) begin
            errors++; $display("FAIL carry_in: got %h exp 01", acc_out);
        end
        wait_halt(10);
        // r1 still holds 5 from the previous program
        checks++;
        if (acc_out !== 8'h06) begin
            errors++; $display("FAIL reg_keep: got %h exp 06", acc_out);
        end
    endtask

    task automatic test_alu();
        logic [7:0] exp_acc [1:19];
        clear_imem();
        imem[0]  = enc(1, 4'd2, 8'h0C);  exp_acc[1]  = 8'h0C;
        imem[1]  = enc(0, 4'd1, 8'd6);   exp_acc[2]  = 8'h0C;
        imem[2]  = enc(1, 4'd2, 8'h0A);  exp_acc[3]  = 8'h0A;
        imem[3]  = enc(0, 4'd4, 8'd6);   exp_acc[4]  = 8'h08;
        imem[4]  = enc(0, 4'd5, 8'd6);   exp_acc[5]  = 8'h0C;
        imem[5]  = enc(0, 4'd6, 8'd6);   exp_acc[6]  = 8'h00;
        imem[6]  = enc(1, 4'd2, 8'h81);  exp_acc[7]  = 8'h81;
        imem[7]  = enc(0, 4'd7, 8'd0);   exp_acc[8]  = 8'h02;
        imem[8]  = enc(0, 4'd2, 8'd0);   exp_acc[9]  = 8'h03;
        imem[9]  = enc(0, 4'd8, 8'd0);   exp_acc[10] = 8'h01;
        imem[10] = enc(0, 4'd2, 8'd0);   exp_acc[11] = 8'h02;
        imem[11] = enc(1, 4'd2, 8'h05);  exp_acc[12] = 8'h05;
        imem[12] = enc(0, 4'd3, 8'd6);   exp_acc[13] = 8'hF9;
        imem[13] = enc(0, 4'd3, 8'd0);   exp_acc[14] = 8'hF8;
        imem[14] = enc(1, 4'd2, 8'h01);  exp_acc[15] = 8'h01;
        imem[15] = enc(0, 4'd8, 8'd0);   exp_acc[16] = 8'h00;
        imem[16] = enc(0, 4'd11, 8'd0);  exp_acc[17] = 8'h00;
        imem[17] = enc(0, 4'd2, 8'd0);   exp_acc[18] = 8'h00;
        imem[18] = enc(0, 4'd0, 8'd6);   exp_acc[19] = 8'h0C;
        imem[19] = enc(0, 4'd15, 8'd0);
        pulse_start();
        for (int k = 1; k <= 19; k++) begin
            @(negedge CLK);
            checks++;
            if (acc_out !== exp_acc[k]) begin
                errors++;
                $display("FAIL alu_step%0d: got %h exp %h",
                         k, acc_out, exp_acc[k]);
            end
        end
        wait_halt(5);
    endtask

    task automatic test_store();
        int hi;
        bit bad;
        clear_imem();
        imem[0] = enc(1, 4'd2, 8'h40);
        imem[1] = enc(0, 4'd1, 8'd3);
        imem[2] = enc(1, 4'd2, 8'h5A);
        imem[3] = enc(0, 4'd10, 8'd3);
        imem[4] = enc(0, 4'd15, 8'd0);
        pulse_start();
        repeat (3) @(negedge CLK);
        checks++;
        if (mem_req !== 1'b0) begin
            errors++; $display("FAIL st_req_decode: got %b exp 0", mem_req);
        end
        hi = 0; bad = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge CLK);
            if (mem_req) begin
                hi++;
                if (mem_addr !== 8'h40 || mem_wdata !== 8'h5A ||
                    mem_we !== 1'b1) bad = 1;
                mem_ack = (hi == 3);
            end else begin
                mem_ack = 1'b0;
                if (hi > 0) break;
            end
        end
        mem_ack = 1'b0;
        checks++;
        if (hi !== 3) begin
            errors++; $display("FAIL st_req_len: got %0d exp 3", hi);
        end
        checks++;
        if (bad) begin
            errors++; $display("FAIL st_stable: got unstable exp stable");
        end
`ifdef ACC_CORE_STALL_CNT_EN
        checks++;
        if (stall_ct !== 3) begin
            errors++; $display("FAIL stall_ct: got %0d exp 3", stall_ct);
        end
`endif
        wait_halt(5);
        checks++;
        if (instr_ct !== 4 || cycle_ct !== 8) begin
            errors++;
            $display("FAIL st_cnt: got %0d/%0d exp 4/8", instr_ct, cycle_ct);
        end
    endtask

    task automatic test_load();
        clear_imem();
        imem[0] = enc(1, 4'd2, 8'h33);
        imem[1] = enc(0, 4'd1, 8'd4);
        imem[2] = enc(0, 4'd9, 8'd4);
        imem[3] = enc(0, 4'd15, 8'd0);
        pulse_start();
        repeat (3) @(negedge CLK);
        checks++;
        if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 8'h33) begin
            errors++;
            $display("FAIL ld_req: got %b/%b/%h exp 1/0/33",
                     mem_req, mem_we, mem_addr);
        end
        mem_rdata = 8'hA5; mem_ack = 1'b1;
        @(negedge CLK);
        mem_ack = 1'b0;
        checks++;
        if (acc_out !== 8'hA5) begin
            errors++; $display("FAIL ld_acc: got %h exp a5", acc_out);
        end
        checks++;
        if (instr_addr !== 8'h03 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL ld_next: got %h/%b exp 03/0", instr_addr, mem_req);
        end
        checks++;
        if (instr_ct !== 3) begin
            errors++; $display("FAIL ld_ict: got %0d exp 3", instr_ct);
        end
        wait_halt(5);
    endtask

    task automatic test_start_in_wait();
        clear_imem();
        imem[0] = enc(1, 4'd2, 8'h10);
        imem[1] = enc(0, 4'd1, 8'd5);
        imem[2] = enc(0, 4'd9, 8'd5);
        imem[3] = enc(0, 4'd15, 8'd0);
        pulse_start();
        repeat (3) @(negedge CLK);
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        checks++;
        if (mem_req !== 1'b0 || instr_addr !== 8'h00) begin
            errors++;
            $display("FAIL sw_drop: got %b/%h exp 0/00", mem_req, instr_addr);
        end
        checks++;
        if (cycle_ct !== 0 || instr_ct !== 0 || acc_out !== 8'h00) begin
            errors++;
            $display("FAIL sw_clear: got %0d/%0d/%h exp 0/0/00",
                     cycle_ct, instr_ct, acc_out);
        end
        imem[0] = enc(0, 4'd15, 8'd0);
        mem_rdata = 8'hEE; mem_ack = 1'b1;
        @(negedge CLK);
        mem_ack = 1'b0;
        checks++;
        if (acc_out !== 8'h00 || Halt !== 1'b1) begin
            errors++;
            $display("FAIL sw_late_ack: got %h/%b exp 00/1", acc_out, Halt);
        end
        checks++;
        if (cycle_ct !== 1 || instr_ct !== 0) begin
            errors++;
            $display("FAIL sw_cnt: got %0d/%0d exp 1/0", cycle_ct, instr_ct);
        end
    endtask

    task automatic test_wrap();
        clear_imem();
        imem[0] = enc(1, 4'd1, 8'hFF);
        pulse_start();
        @(negedge CLK);
        checks++;
        if (instr_addr !== 8'hFF) begin
            errors++; $display("FAIL jmp_ff: got %h exp ff", instr_addr);
        end
        @(negedge CLK);
        checks++;
        if (instr_addr !== 8'h00) begin
            errors++; $display("FAIL pc_wrap: got %h exp 00", instr_addr);
        end
    endtask

    task automatic test_async_reset();
        clear_imem();
        imem[0] = enc(0, 4'd9, 8'd0);
        pulse_start();
        @(negedge CLK);
        checks++;
        if (mem_req !== 1'b1) begin
            errors++; $display("FAIL ar_pre: got %b exp 1", mem_req);
        end
        #2 RST_n = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0 || Halt !== 1'b1) begin
            errors++;
            $display("FAIL ar_drop: got %b/%b exp 0/1", mem_req, Halt);
        end
        @(negedge CLK);
        RST_n = 1'b1;
    endtask

    task automatic test_saturate();
        @(negedge CLK); start2 = 1'b1;
        @(negedge CLK); start2 = 1'b0;
        repeat (10) @(negedge CLK);
        checks++;
        if (cycle_ct2 !== 4'd10 || instr_ct2 !== 4'd10) begin
            errors++;
            $display("FAIL sat_mid: got %0d/%0d exp 10/10",
                     cycle_ct2, instr_ct2);
        end
        repeat (20) @(negedge CLK);
        checks++;
        if (cycle_ct2 !== 4'd15 || instr_ct2 !== 4'd15) begin
            errors++;
            $display("FAIL sat_hold: got %0d/%0d exp 15/15",
                     cycle_ct2, instr_ct2);
        end
    endtask

    initial begin
        test_reset();
        test_add_prog();
        test_carry_bz();
        test_alu();
        test_store();
        test_load();
        test_start_in_wait();
        test_wrap();
        test_async_reset();
        test_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
